// File: rtl/fifo_pkg.sv
// Shared FIFO definitions used by fifo_top and its read-side drain controller.
package fifo_pkg;

   localparam int BITS  = 32;
   localparam int DEPTH = 4;

   typedef enum logic [1:0] {IDLE, POP, WAIT, HOLD} drain_state_t;

   typedef logic [BITS-1:0] fifo_word_t;

endpackage

// File: rtl/fifo_drain.sv
// Read-side controller for fifo_top: pops one word at a time and presents it on a valid/ready stream.
// Optional macro FIFO_DRAIN_PARITY_EN adds m_par_o and a sticky par_err_o head-stability check.
module fifo_drain
   import fifo_pkg::*;
#(
   parameter int BITS    = 32,
   parameter int POP_LAT = 1,
   parameter int CNT_W   = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             enable_i,
   input  logic             fifo_pnding_i,
   input  logic [BITS-1:0]  fifo_data_i,
   output logic             fifo_pop_o,
   output logic             m_valid_o,
   output logic [BITS-1:0]  m_data_o,
   input  logic             m_ready_i,
`ifdef FIFO_DRAIN_PARITY_EN
   output logic             m_par_o,
   output logic             par_err_o,
`endif
   output logic             busy_o,
   output logic [CNT_W-1:0] word_cnt_o
);

   localparam int         LAT_M1   = (POP_LAT > 0) ? POP_LAT - 1 : 0;
   localparam logic [1:0] LAT_LOAD = 2'(LAT_M1);

   drain_state_t     state_q, state_d;
   logic [1:0]       lat_q, lat_d;
   logic             pop_q, pop_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic [BITS-1:0]  data_q, data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             capture;
   logic             handshake;

   function automatic logic even_parity(input logic [BITS-1:0] w);
      return ^w;
   endfunction

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (enable_i && fifo_pnding_i) state_d = POP;
         POP:  state_d = (POP_LAT == 0) ? HOLD : WAIT;
         WAIT: if (lat_q == 2'd0) state_d = HOLD;
         HOLD: begin
            // Decide on the next pop only once the held word has been taken.
            if (valid_q && m_ready_i) begin
               state_d = (fifo_pnding_i && enable_i) ? POP : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      capture   = ((state_q == POP) && (POP_LAT == 0)) ||
                  ((state_q == WAIT) && (lat_q == 2'd0));
      handshake = valid_q && m_ready_i;

      lat_d = lat_q;
      if (state_q == POP) begin
         lat_d = LAT_LOAD;
      end else if ((state_q == WAIT) && (lat_q != 2'd0)) begin
         lat_d = lat_q - 2'd1;
      end

      data_d  = capture ? fifo_data_i : data_q;
      cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, handshake};
      // Outputs are registered alongside the state they belong to.
      pop_d   = (state_d == POP);
      valid_d = (state_d == HOLD);
      busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lat_q   <= 2'd0;
         pop_q   <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         lat_q   <= lat_d;
         pop_q   <= pop_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

   assign fifo_pop_o = pop_q;
   assign m_valid_o  = valid_q;
   assign m_data_o   = data_q;
   assign busy_o     = busy_q;
   assign word_cnt_o = cnt_q;

`ifdef FIFO_DRAIN_PARITY_EN
   logic par_q, par_d;
   logic chk_q, chk_d;
   logic err_q, err_d;

   always_comb begin
      par_d = capture ? even_parity(fifo_data_i) : par_q;
      chk_d = capture;
      // First HOLD cycle: the FIFO must still present the word just captured.
      err_d = err_q | (chk_q && (state_q == HOLD) && (fifo_data_i != data_q));
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         par_q <= 1'b0;
         chk_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         par_q <= par_d;
         chk_q <= chk_d;
         err_q <= err_d;
      end
   end

   assign m_par_o   = par_q;
   assign par_err_o = err_q;
`else
   logic unused_par;
   assign unused_par = even_parity(data_q);
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// Randomized self-checking bench for fifo_drain against a queue-based FIFO and stream scoreboard.
module tb_fifo_drain;
   import fifo_pkg::*;

   localparam int W  = 32;
   localparam int PL = 3;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          en  = 1'b0;
   logic          pnd = 1'b0;
   logic [W-1:0]  fd  = '0;
   logic          mr  = 1'b0;
   logic          pop, mv, busy;
   logic [W-1:0]  md;
   logic [CW-1:0] wc;
`ifdef FIFO_DRAIN_PARITY_EN
   logic          par, perr;
`endif

   fifo_drain #(.BITS(W), .POP_LAT(PL), .CNT_W(CW)) dut (
      .clk_i(clk), .rst_i(rst), .enable_i(en), .fifo_pnding_i(pnd), .fifo_data_i(fd),
      .fifo_pop_o(pop), .m_valid_o(mv), .m_data_o(md), .m_ready_i(mr),
`ifdef FIFO_DRAIN_PARITY_EN
      .m_par_o(par), .par_err_o(perr),
`endif
      .busy_o(busy), .word_cnt_o(wc)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] fq[$];      // FIFO contents
   logic [W-1:0] sb[$];      // expected delivery order
   int           due_q[$];   // edge index at which a popped word must be on fd
   logic [W-1:0] word_q[$];
   logic [W-1:0] rd_r = '0;
   int           n = 0, pops = 0, acc = 0;
   logic         pop_prev = 1'b0, hs_prev = 1'b0;
   logic [W-1:0] hs_data = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: account for what the DUT sampled at the last posedge, then drive the next inputs.
   task automatic cycle(input bit push, input logic [W-1:0] w, input logic rdy, input logic ena);
      @(negedge clk);
      n++;
      if (pop_prev) begin
         pops++;
         if (fq.size() != 0) begin
            word_q.push_back(fq.pop_front());
            due_q.push_back(n + PL - 1);
         end
      end
      if (hs_prev) begin
         acc++;
         check("sb_nonempty", sb.size() != 0, 1);
         if (sb.size() != 0) check("order", hs_data, sb.pop_front());
      end
      while (due_q.size() != 0 && due_q[0] <= n) begin
         rd_r = word_q.pop_front();
         void'(due_q.pop_front());
      end
      if (push) begin
         fq.push_back(w);
         sb.push_back(w);
      end
      mr  = rdy;
      en  = ena;
      pnd = (fq.size() != 0);
      if (PL == 0) fd = (fq.size() != 0) ? fq[0] : '0;
      else         fd = rd_r;
      if (pop) check("pop_on_empty", fq.size() != 0, 1);
      pop_prev = pop;
      hs_prev  = mv && mr;
      hs_data  = md;
   endtask

   task automatic wait_valid(input logic rdy, input string tag);
      for (int i = 0; i < 40 && !mv; i++) cycle(1'b0, '0, rdy, 1'b1);
      check(tag, mv, 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_pop", pop, 0);
      check("rst_valid", mv, 0);
      check("rst_busy", busy, 0);
      check("rst_cnt", wc, 0);
      check("rst_data", md, 0);
      fq.delete(); sb.delete(); due_q.delete(); word_q.delete();
      rd_r = '0; acc = 0; pop_prev = 1'b0; hs_prev = 1'b0;
      pnd = 1'b0; fd = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [W-1:0] d0;
      int p0, gap;
      logic held, any_pop, any_busy;

      do_reset();

      // Write-then-drain
      p0 = pops;
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, W'(32'h0A + i), 1'b1, 1'b0);
      for (int i = 0; i < 40; i++) cycle(1'b0, '0, 1'b1, 1'b1);
      check("drain_pops", pops - p0, DEPTH);
      check("drain_cnt", wc, DEPTH);
      check("drain_acc", wc, acc[CW-1:0]);
      check("drain_idle", busy, 0);
      check("drain_empty", pnd, 0);

      // Backpressure
      cycle(1'b1, 32'h100, 1'b0, 1'b1);
      cycle(1'b1, 32'h101, 1'b0, 1'b1);
      wait_valid(1'b0, "bp_valid");
      d0 = md; p0 = pops; held = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, '0, 1'b0, 1'b1);
         held &= mv && (md == d0);
      end
      check("bp_first", d0, 32'h100);
      check("bp_held", held, 1);
      check("bp_no_pop", pops - p0, 0);
      cycle(1'b0, '0, 1'b1, 1'b1);
      gap = 0;
      for (int i = 0; i < 20; i++) begin
         cycle(1'b0, '0, 1'b1, 1'b1);
         if (mv) break;
         gap++;
      end
      check("bp_gap", gap, PL + 1);
      check("bp_second", md, 32'h101);
      for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, 1'b1);

      // Empty FIFO
      any_pop = 1'b0; any_busy = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cycle(1'b0, '0, 1'b1, 1'b1);
         any_pop |= pop; any_busy |= busy;
      end
      check("empty_pop", any_pop, 0);
      check("empty_busy", any_busy, 0);

      // Reset while waiting on the FIFO read latency
      cycle(1'b1, 32'h55, 1'b0, 1'b1);
      for (int i = 0; i < 10 && !(busy && !pop && !mv); i++) cycle(1'b0, '0, 1'b0, 1'b1);
      check("reach_wait", busy && !pop && !mv, 1);
      do_reset();
      for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, 1'b1);
      check("post_rst_busy", busy, 0);

      // Random push / random ready
      for (int i = 0; i < 200; i++)
         cycle($urandom_range(0, 2) == 0, $urandom, 1'($urandom_range(0, 1)), 1'b1);
      for (int i = 0; i < 300 && (sb.size() != 0 || busy); i++) cycle(1'b0, '0, 1'b1, 1'b1);
      cycle(1'b0, '0, 1'b1, 1'b1);
      check("rnd_sb_empty", sb.size(), 0);
      check("rnd_fifo_empty", fq.size(), 0);
      check("rnd_cnt", wc, acc[CW-1:0]);

`ifdef FIFO_DRAIN_PARITY_EN
      do_reset();
      cycle(1'b1, 32'h7, 1'b0, 1'b1);
      cycle(1'b1, 32'h3, 1'b0, 1'b1);
      wait_valid(1'b0, "par_v1");
      check("par_d1", md, 32'h7);
      check("par_p1", par, 1);
      cycle(1'b0, '0, 1'b1, 1'b1);
      cycle(1'b0, '0, 1'b0, 1'b1);
      wait_valid(1'b0, "par_v2");
      check("par_d2", md, 32'h3);
      check("par_p2", par, 0);
      for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, 1'b1);
      check("par_err", perr, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
